x3q_mem_arbiter: RTL and testbench
==================================

# x3q_mem_arbiter

Parametrised N-channel memory request arbiter for the x3q16 memory protocol. It lets several requesters share one single-outstanding memory port, such as instruction fetch, data load/store and a UART DMA engine. Each requester uses the same pulse-request / ready-or-write-complete handshake the core uses today. Over that protocol the block adds per-channel request latching, round-robin arbitration and a watchdog timeout.

## Interface
- `N_CH`, 3: number of requester channels (≥1).
- `AW`, 16: address width.
- `DW`, 16: data width.
- `TIMEOUT`, 255: cycles in WAIT before a request is aborted; 0 disables the watchdog.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `ch_req`  in  N_CH  one-cycle request pulse per channel.
- `ch_type`  in  N_CH  0 = read, 1 = write; sampled with `ch_req`.
- `ch_addr`  in  N_CH*AW  packed addresses; channel i occupies [i*AW +: AW].
- `ch_wdata`  in  N_CH*DW  packed write data; channel i occupies [i*DW +: DW].
- `ch_busy`  out  N_CH  channel has a latched, uncompleted request.
- `ch_ready`  out  N_CH  one-cycle pulse: read completed, `ch_rdata` valid.
- `ch_wdone`  out  N_CH  one-cycle pulse: write completed.
- `ch_timeout`  out  N_CH  one-cycle pulse: request aborted by the watchdog.
- `ch_rdata`  out  DW  shared read data, valid only while a `ch_ready` bit is high.
- `mem_request`  out  1  one-cycle request pulse to memory.
- `mem_type`  out  1  0 = read, 1 = write.
- `mem_address`  out  AW  request address.
- `mem_wdata`  out  DW  write data.
- `mem_rdata`  in  DW  memory read data.
- `mem_ready`  in  1  read data valid pulse.
- `mem_write_complete`  in  1  write done pulse.

## Operation
- Each channel has one slot holding `pending`, type, addr and wdata.
- On `ch_req[i]`:
  - If the slot is free, latch the fields and set `pending[i]`.
  - If the slot is already pending, the request is dropped and the slot is unchanged.
- `ch_busy = pending`.
- States:
  - IDLE: if any `pending` bit is set, pick the winner. The search starts at `last_grant+1` and wraps modulo N_CH.
    - Drive the winner's fields onto `mem_type`/`mem_address`/`mem_wdata`.
    - Pulse `mem_request` and clear `timer`.
    - Set `last_grant` to the winner and go to WAIT.
  - WAIT, read (`mem_type=0`): on `mem_ready`, set `ch_rdata <= mem_rdata`, pulse `ch_ready[g]`, clear `pending[g]`, go to IDLE.
  - WAIT, write (`mem_type=1`): on `mem_write_complete`, pulse `ch_wdone[g]`, clear `pending[g]`, go to IDLE.
  - WAIT, watchdog: if `TIMEOUT≠0` and `timer == TIMEOUT-1` with no matching response, pulse `ch_timeout[g]`, clear `pending[g]`, go to IDLE. Otherwise `timer++`.
- A response that does not match the current type, or any response while in IDLE, is ignored.
- `mem_type`, `mem_address` and `mem_wdata` are registered and held stable from grant until the next grant.
- `timer` is ceil(log2(TIMEOUT+1)) bits wide (min 1) and saturates only via the timeout exit.
- Simultaneous `ch_req[g]` on the completion or timeout edge of channel g: the slot clears and latches the new request in the same edge, so the new request wins. `pending[g]` stays 1.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - `pending=0`, `timer=0`;
  - `last_grant=N_CH-1`, so channel 0 has first priority.
- Reset mid-WAIT drops all latched requests; no completion or timeout pulse is produced.
- `ch_req` sampled at edge E0: `ch_busy` is high after E0. If the arbiter is IDLE with no other winner, `mem_request` is high for exactly the cycle after E1.
- Memory response sampled at edge Ek: the `ch_ready`/`ch_wdone` pulse and `ch_rdata` are valid for the cycle after Ek, and `ch_busy` drops after Ek. The earliest next `mem_request` is after Ek+1.
- Minimum turnaround per transaction is 2 cycles plus memory latency. The block has at most one outstanding memory request.
- Timeout: the `ch_timeout` pulse appears in the cycle after the TIMEOUT-th WAIT cycle following the `mem_request` cycle.

## Test plan
- Single read: ch1 reads addr 0x1234; memory answers `mem_rdata=0xBEEF` 3 cycles later. Expected: one `mem_request` with address 0x1234 and type 0, then `ch_ready=3'b010` for one cycle with `ch_rdata=0xBEEF`, and `ch_busy[1]` drops.
- Single write: ch2 writes 0x00A5 to 0x8000; `mem_write_complete` arrives 2 cycles later. Expected: `mem_wdata=0x00A5`, `mem_type=1`, then `ch_wdone=3'b100` pulse; a spurious `mem_ready` during WAIT is ignored.
- Round-robin: ch0, ch1 and ch2 request in the same cycle, each with 1-cycle memory latency. Expected grant order 0,1,2. Then ch0 and ch2 request again with `last_grant=2`, so the order is 0,2.
- Drop on busy: a second `ch_req[0]` with addr 0x0002 while ch0 is pending on 0x0001 yields exactly one memory access, to 0x0001. A new request on the completion edge is accepted and served next.
- Timeout: with TIMEOUT=4 and no memory response, `ch_timeout[0]` pulses after the 4th WAIT cycle and `ch_busy[0]` drops. The next pending channel is granted one cycle later.
- Reset mid-WAIT: assert `reset` while ch1 is outstanding. Expected: all outputs 0 and `ch_busy=0`. A later late `mem_ready` produces no `ch_ready` pulse.

Source files
------------

// File: rtl/x3q_mem_arbiter.sv
// rtl/x3q_mem_arbiter.sv - N-channel round-robin arbiter onto one single-outstanding x3q16 memory port
module x3q_mem_arbiter #(
  parameter int N_CH    = 3,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]    ch_req,
  input  logic [N_CH-1:0]    ch_type,
  input  logic [N_CH*AW-1:0] ch_addr,
  input  logic [N_CH*DW-1:0] ch_wdata,
  output logic [N_CH-1:0]    ch_busy,
  output logic [N_CH-1:0]    ch_ready,
  output logic [N_CH-1:0]    ch_wdone,
  output logic [N_CH-1:0]    ch_timeout,
  output logic [DW-1:0]      ch_rdata,
  output logic             mem_request,
  output logic             mem_type,
  output logic [AW-1:0]    mem_address,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ready,
  input  logic             mem_write_complete
);

  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state, state_n;
  logic [N_CH-1:0] pending, slot_type, clr_mask;
  logic [AW-1:0]   slot_addr  [N_CH];
  logic [DW-1:0]   slot_wdata [N_CH];
  logic [GW-1:0]   grant, last_grant, winner, idx;
  logic            win_found;
  logic [TW-1:0]   timer;
  logic            rd_done, wr_done, to_done, finish;

  assign ch_busy = pending;

  // Round-robin search begins just after the previous winner.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = GW'((int'(last_grant) + k) % N_CH);
      if (!win_found && pending[idx]) begin
        win_found = 1'b1;
        winner    = idx;
      end
    end
  end

  always_comb begin
    rd_done  = (state == S_WAIT) && !mem_type && mem_ready;
    wr_done  = (state == S_WAIT) && mem_type && mem_write_complete;
    to_done  = (state == S_WAIT) && !rd_done && !wr_done && (TIMEOUT != 0) &&
               (timer == TW'(TIMEOUT - 1));
    finish   = rd_done || wr_done || to_done;
    clr_mask = '0;
    if (finish) clr_mask[grant] = 1'b1;
    state_n  = state;
    case (state)
      S_IDLE:  if (win_found) state_n = S_WAIT;
      S_WAIT:  if (finish) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pending     <= '0;
      slot_type   <= '0;
      grant       <= '0;
      last_grant  <= GW'(N_CH - 1);
      timer       <= '0;
      ch_ready    <= '0;
      ch_wdone    <= '0;
      ch_timeout  <= '0;
      ch_rdata    <= '0;
      mem_request <= 1'b0;
      mem_type    <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      state       <= state_n;
      mem_request <= (state == S_IDLE) && win_found;
      ch_ready    <= '0;
      ch_wdone    <= '0;
      ch_timeout  <= '0;
      if (state == S_IDLE) begin
        if (win_found) begin
          grant       <= winner;
          last_grant  <= winner;
          mem_type    <= slot_type[winner];
          mem_address <= slot_addr[winner];
          mem_wdata   <= slot_wdata[winner];
          timer       <= '0;
        end
      end else begin
        if (rd_done) begin
          ch_rdata        <= mem_rdata;
          ch_ready[grant] <= 1'b1;
        end
        if (wr_done) ch_wdone[grant] <= 1'b1;
        if (to_done) ch_timeout[grant] <= 1'b1;
        if (!finish) timer <= timer + 1'b1;
      end
      // A request landing on its own channel's completion edge refills the slot.
      for (int i = 0; i < N_CH; i++) begin
        if (ch_req[i] && (!pending[i] || clr_mask[i])) begin
          pending[i]    <= 1'b1;
          slot_type[i]  <= ch_type[i];
          slot_addr[i]  <= ch_addr[i*AW +: AW];
          slot_wdata[i] <= ch_wdata[i*DW +: DW];
        end else if (clr_mask[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_x3q_mem_arbiter.sv
// tb/tb_x3q_mem_arbiter.sv - directed scoreboard bench for x3q_mem_arbiter
module tb_x3q_mem_arbiter;

  localparam int N_CH = 3;
  localparam int AW   = 16;
  localparam int DW   = 16;

  typedef struct {
    logic          typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [8:0]    pulses;
    bit            is_read;
    logic [DW-1:0] rdata;
  } resp_exp_t;

  logic clk, reset;
  logic [N_CH-1:0]    ch_req, ch_type, ch_busy, ch_ready, ch_wdone, ch_timeout;
  logic [N_CH*AW-1:0] ch_addr;
  logic [N_CH*DW-1:0] ch_wdata;
  logic [DW-1:0]      ch_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]      mem_address;
  logic               mem_request, mem_type, mem_ready, mem_write_complete;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];
  int n_cmp = 0, n_bad = 0;
  int cyc_cnt = 0, last_req_cyc = 0, n_req = 0, n_req_exp = 0;

  x3q_mem_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ch_req(ch_req), .ch_type(ch_type), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_busy(ch_busy), .ch_ready(ch_ready), .ch_wdone(ch_wdone), .ch_timeout(ch_timeout),
    .ch_rdata(ch_rdata),
    .mem_request(mem_request), .mem_type(mem_type), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_write_complete(mem_write_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_mem(input logic typ, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_exp_t m;
    m.typ = typ; m.addr = a; m.wdata = d;
    exp_mem.push_back(m);
    n_req_exp++;
  endtask

  task automatic push_resp(input logic [8:0] p, input bit rd, input logic [DW-1:0] d);
    resp_exp_t r;
    r.pulses = p; r.is_read = rd; r.rdata = d;
    exp_resp.push_back(r);
  endtask

  task automatic mon();
    mem_exp_t   m;
    resp_exp_t  r;
    logic [8:0] p;
    p = {ch_ready, ch_wdone, ch_timeout};
    if (mem_request) begin
      n_req++;
      last_req_cyc = cyc_cnt;
      if (exp_mem.size() == 0) chk("mem_unexpected", 64'd1, 64'd0);
      else begin
        m = exp_mem.pop_front();
        chk("mem_type", 64'(mem_type), 64'(m.typ));
        chk("mem_addr", 64'(mem_address), 64'(m.addr));
        if (m.typ) chk("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
      end
    end
    if (p != 9'd0) begin
      if (exp_resp.size() == 0) chk("resp_unexpected", 64'(p), 64'd0);
      else begin
        r = exp_resp.pop_front();
        chk("ch_pulses", 64'(p), 64'(r.pulses));
        if (r.is_read) chk("ch_rdata", 64'(ch_rdata), 64'(r.rdata));
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_cnt++;
    mon();
  endtask

  // Waits (bounded) for the current mem_request, then answers it next edge.
  task automatic serve(input bit wr, input logic [DW-1:0] d);
    int n = 0;
    while (!mem_request && n < 20) begin cyc(); n++; end
    if (n == 20) chk("serve_wait_expired", 64'd1, 64'd0);
    mem_ready          = !wr;
    mem_write_complete = wr;
    mem_rdata          = d;
    cyc();
    mem_ready          = 1'b0;
    mem_write_complete = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; ch_req = '0; ch_type = '0; ch_addr = '0; ch_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0; mem_write_complete = 1'b0;
    cyc(); cyc();
    chk("reset_outputs", 64'({ch_busy, ch_ready, ch_wdone, ch_timeout, ch_rdata,
        mem_request, mem_type, mem_address, mem_wdata}), 64'd0);
    reset = 1'b0;
    cyc();

    // single read, ch1, 3-cycle memory latency
    ch_req = 3'b010; ch_type = 3'b000; ch_addr[AW +: AW] = 16'h1234;
    push_mem(1'b0, 16'h1234, 16'h0);
    push_resp({3'b010, 3'b000, 3'b000}, 1'b1, 16'hBEEF);
    cyc();
    chk("t1_busy", 64'(ch_busy), 64'(3'b010));
    ch_req = '0;
    cyc();
    chk("t1_req_timing", 64'(mem_request), 64'd1);
    cyc(); cyc();
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    cyc();
    mem_ready = 1'b0;
    chk("t1_busy_drop", 64'(ch_busy), 64'd0);
    cyc();
    chk("t1_ready_one_cycle", 64'(ch_ready), 64'd0);

    // single write, ch2, with a spurious mem_ready during WAIT
    ch_req = 3'b100; ch_type = 3'b100; ch_addr[2*AW +: AW] = 16'h8000;
    ch_wdata[2*DW +: DW] = 16'h00A5;
    push_mem(1'b1, 16'h8000, 16'h00A5);
    push_resp({3'b000, 3'b100, 3'b000}, 1'b0, 16'h0);
    cyc();
    ch_req = '0; ch_type = '0;
    cyc();
    chk("t2_req_timing", 64'(mem_request), 64'd1);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("t2_spurious_ignored", 64'(ch_busy), 64'(3'b100));
    mem_write_complete = 1'b1;
    cyc();
    mem_write_complete = 1'b0;
    chk("t2_busy_drop", 64'(ch_busy), 64'd0);

    // round robin: all three, then ch0+ch2 with last_grant = 2
    ch_req = 3'b111; ch_addr = {16'h0012, 16'h0011, 16'h0010};
    push_mem(1'b0, 16'h0010, 16'h0); push_resp({3'b001, 6'b0}, 1'b1, 16'hA000);
    push_mem(1'b0, 16'h0011, 16'h0); push_resp({3'b010, 6'b0}, 1'b1, 16'hA001);
    push_mem(1'b0, 16'h0012, 16'h0); push_resp({3'b100, 6'b0}, 1'b1, 16'hA002);
    cyc();
    ch_req = '0;
    serve(1'b0, 16'hA000); serve(1'b0, 16'hA001); serve(1'b0, 16'hA002);
    ch_req = 3'b101; ch_addr = {16'h0022, 16'h0021, 16'h0020};
    push_mem(1'b0, 16'h0020, 16'h0); push_resp({3'b001, 6'b0}, 1'b1, 16'hB000);
    push_mem(1'b0, 16'h0022, 16'h0); push_resp({3'b100, 6'b0}, 1'b1, 16'hB002);
    cyc();
    ch_req = '0;
    serve(1'b0, 16'hB000); serve(1'b0, 16'hB002);

    // drop on busy, then refill on the completion edge
    ch_req = 3'b001; ch_addr[0 +: AW] = 16'h0001;
    push_mem(1'b0, 16'h0001, 16'h0); push_resp({3'b001, 6'b0}, 1'b1, 16'h1111);
    cyc();
    ch_req = '0;
    cyc();
    ch_req = 3'b001; ch_addr[0 +: AW] = 16'h0002;
    cyc();
    push_mem(1'b0, 16'h0003, 16'h0); push_resp({3'b001, 6'b0}, 1'b1, 16'h3333);
    ch_addr[0 +: AW] = 16'h0003; mem_ready = 1'b1; mem_rdata = 16'h1111;
    cyc();
    ch_req = '0; mem_ready = 1'b0;
    chk("t4_busy_kept", 64'(ch_busy), 64'(3'b001));
    serve(1'b0, 16'h3333);

    // watchdog timeout on ch0 while ch1 waits
    ch_req = 3'b001; ch_addr[0 +: AW] = 16'h0040;
    push_mem(1'b0, 16'h0040, 16'h0); push_resp({6'b0, 3'b001}, 1'b0, 16'h0);
    push_mem(1'b0, 16'h0041, 16'h0); push_resp({3'b010, 6'b0}, 1'b1, 16'h4141);
    cyc();
    ch_req = '0;
    cyc();
    ch_req = 3'b010; ch_addr[AW +: AW] = 16'h0041;
    cyc();
    ch_req = '0;
    n = 0;
    while (ch_timeout == '0 && n < 20) begin cyc(); n++; end
    chk("t5_timeout_seen", 64'(ch_timeout), 64'(3'b001));
    chk("t5_timeout_latency", 64'(cyc_cnt - last_req_cyc), 64'd4);
    chk("t5_busy", 64'(ch_busy), 64'(3'b010));
    cyc();
    chk("t5_next_grant", 64'(mem_request), 64'd1);
    serve(1'b0, 16'h4141);

    // reset while ch1 is outstanding, then a late mem_ready
    ch_req = 3'b010; ch_addr[AW +: AW] = 16'h0099;
    push_mem(1'b0, 16'h0099, 16'h0);
    cyc();
    ch_req = '0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk("t6_reset_outputs", 64'({ch_busy, ch_ready, ch_wdone, ch_timeout, ch_rdata,
        mem_request, mem_type, mem_address, mem_wdata}), 64'd0);
    reset = 1'b0;
    cyc();
    mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    cyc();
    mem_ready = 1'b0;
    chk("t6_no_ready", 64'(ch_ready), 64'd0);
    cyc(); cyc();

    chk("mem_req_count", 64'(n_req), 64'(n_req_exp));
    chk("mem_queue_left", 64'(exp_mem.size()), 64'd0);
    chk("resp_queue_left", 64'(exp_resp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
